seq_divider_sm: RTL and testbench



---
 rtl/seq_divider_sm.sv | 142 ++++++++++++++
 tb/tb_seq_divider_sm.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_sm.sv
// seq_divider_sm: iterative signed/unsigned integer divider, one quotient
// bit per clock (restoring algorithm), started through a req/busy handshake.
//
// Ports:
//   clk, rstn          clock (rising edge), asynchronous active-low reset
//   req                start request, taken only while busy=0
//   signed_mode        1: two's-complement operands, 0: unsigned
//   Dividend, Divisor  operands, captured on the accept edge
//   busy               operation in flight, req ignored
//   Q, R               registered quotient / remainder
//   ready              one-cycle pulse when Q/R/dbz/ovf are updated
//   dbz, ovf           divide-by-zero / signed overflow flags of last result
module seq_divider_sm #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         req,
  input  logic         signed_mode,
  input  logic [N-1:0] Dividend,
  input  logic [N-1:0] Divisor,
  output logic         busy,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         ready,
  output logic         dbz,
  output logic         ovf
);

  localparam int CW = $clog2(N+1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  rem_q, quo_q, dvs_q, q_q, r_q;
  logic [CW-1:0] cnt_q;
  logic          sgn_q_q, sgn_r_q, dz_q, ovp_q;
  logic          ready_q, dbz_q, ovf_q;

  logic          accept;
  logic          div_zero;
  logic [N-1:0]  abs_dvd, abs_dvs;
  logic [N:0]    part;
  logic [N-1:0]  diff;
  logic          ge;

  assign accept   = (state_q == IDLE) && req;
  assign div_zero = (Divisor == '0);

  always_comb begin
    abs_dvd = (signed_mode && Dividend[N-1]) ? -Dividend : Dividend;
    abs_dvs = (signed_mode && Divisor[N-1])  ? -Divisor  : Divisor;
    // Partial remainder always fits N+1 bits; when it is >= divisor the
    // difference is < divisor, so the low N bits of the subtraction suffice.
    part    = {rem_q, quo_q[N-1]};
    ge      = (part >= {1'b0, dvs_q});
    diff    = part[N-1:0] - dvs_q;
  end

  // ---- state register ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---- next state ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = div_zero ? FIX : CALC;
      CALC:    if (cnt_q == CW'(1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- outputs ----
  always_comb begin
    busy  = (state_q != IDLE);
    ready = ready_q;
    Q     = q_q;
    R     = r_q;
    dbz   = dbz_q;
    ovf   = ovf_q;
  end

  // ---- datapath ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      sgn_q_q <= 1'b0;
      sgn_r_q <= 1'b0;
      dz_q    <= 1'b0;
      ovp_q   <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      ready_q <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          // sign flags already fold in the mode, so FIX needs no mode bit
          sgn_q_q <= signed_mode & (Dividend[N-1] ^ Divisor[N-1]);
          sgn_r_q <= signed_mode & Dividend[N-1];
          dz_q    <= div_zero;
          ovp_q   <= signed_mode && (Dividend == {1'b1, {(N-1){1'b0}}})
                     && (Divisor == '1);
          // on divide-by-zero the raw dividend is parked in quo_q for R
          quo_q   <= div_zero ? Dividend : abs_dvd;
          dvs_q   <= abs_dvs;
          rem_q   <= '0;
          cnt_q   <= CW'(N);
        end
        CALC: begin
          rem_q <= ge ? diff : part[N-1:0];
          quo_q <= {quo_q[N-2:0], ge};
          cnt_q <= cnt_q - CW'(1);
        end
        FIX: begin
          ready_q <= 1'b1;
          dbz_q   <= dz_q;
          if (dz_q) begin
            q_q   <= '1;
            r_q   <= quo_q;
            ovf_q <= 1'b0;
          end else begin
            q_q   <= sgn_q_q ? -quo_q : quo_q;
            r_q   <= sgn_r_q ? -rem_q : rem_q;
            ovf_q <= ovp_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_sm.sv
module tb_seq_divider_sm;
  localparam int N = 16;

  logic         clk = 1'b0, rstn = 1'b0, req = 1'b0, signed_mode = 1'b0;
  logic [N-1:0] Dividend = '0, Divisor = '0;
  logic         busy, ready, dbz, ovf;
  logic [N-1:0] Q, R;

  int n_pass = 0, n_total = 0;

  seq_divider_sm #(.N(N)) dut (
    .clk(clk), .rstn(rstn), .req(req), .signed_mode(signed_mode),
    .Dividend(Dividend), .Divisor(Divisor), .busy(busy), .Q(Q), .R(R),
    .ready(ready), .dbz(dbz), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, truncating division.
  function automatic void model(input logic m, input logic [N-1:0] D, d,
                                output logic [N-1:0] q, r, output logic dz, ov);
    int sD, sd;
    dz = 1'b0; ov = 1'b0;
    if (d == 0) begin
      q = '1; r = D; dz = 1'b1;
    end else if (m) begin
      sD = $signed(D); sd = $signed(d);
      if (sD == -(1 << (N-1)) && sd == -1) begin
        q = N'(1 << (N-1)); r = '0; ov = 1'b1;
      end else begin
        q = N'(sD / sd); r = N'(sD % sd);
      end
    end else begin
      q = D / d; r = D % d;
    end
  endfunction

  function automatic int exp_lat(input logic [N-1:0] d);
    return (d == 0) ? 1 : N + 1;
  endfunction

  function automatic logic [N-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return N'(1 << (N-1));
      2:       return '1;
      3:       return N'($urandom_range(1, 9));
      default: return N'($urandom);
    endcase
  endfunction

  // Issues one request and observes the response; no comparisons here.
  task automatic run_op(input logic m, input logic [N-1:0] D, d,
                        output int lat, output logic [N-1:0] q, r,
                        output logic dz, ov, output int busy_bad,
                        output int nrdy, output logic hold_ok);
    lat = -1; q = '0; r = '0; dz = 1'b0; ov = 1'b0;
    busy_bad = 0; nrdy = 0; hold_ok = 1'b0;
    @(negedge clk); req = 1'b1; signed_mode = m; Dividend = D; Divisor = d;
    @(posedge clk);
    @(negedge clk); req = 1'b0;
    signed_mode = 1'($urandom); Dividend = N'($urandom); Divisor = N'($urandom);
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      if (ready) begin
        nrdy++;
        if (lat < 0) begin
          lat = k; q = Q; r = R; dz = dbz; ov = ovf;
          if (busy) busy_bad++;
        end
      end else if (lat < 0 && !busy) busy_bad++;
      if (lat >= 0 && k == lat + 3) begin
        hold_ok = (Q === q) && (R === r) && (dbz === dz) && (ovf === ov);
        break;
      end
    end
  endtask

  task automatic test_reset();
    #12;
    n_total++; if ({busy, ready, Q, R, dbz, ovf} !== '0)
      $display("FAIL reset_outputs got busy=%b ready=%b Q=%h R=%h dbz=%b ovf=%b exp all 0",
               busy, ready, Q, R, dbz, ovf); else n_pass++;
    @(negedge clk); rstn = 1'b1;
    @(negedge clk);
    n_total++; if ({busy, ready} !== 2'b00)
      $display("FAIL reset_release got busy=%b ready=%b exp 0 0", busy, ready); else n_pass++;
  endtask

  task automatic test_directed();
    logic          m_a [10] = '{0, 1, 1, 1, 0, 1, 0, 1, 0, 0};
    logic [N-1:0]  D_a [10] = '{16'd600, 16'hFFF9, 16'd7, 16'hFFF9, 16'd1234, 16'd1234,
                                16'd10, 16'h8000, 16'h8000, 16'd65535};
    logic [N-1:0]  d_a [10] = '{16'd599, 16'd2, 16'hFFFE, 16'hFFFE, 16'd0, 16'd0,
                                16'd3, 16'hFFFF, 16'hFFFF, 16'd1};
    int lat, bb, nr; logic [N-1:0] q, r, eq, er; logic dz, ov, edz, eov, hold;
    for (int i = 0; i < 10; i++) begin
      model(m_a[i], D_a[i], d_a[i], eq, er, edz, eov);
      run_op(m_a[i], D_a[i], d_a[i], lat, q, r, dz, ov, bb, nr, hold);
      n_total++; if (lat !== exp_lat(d_a[i]))
        $display("FAIL dir%0d latency got %0d exp %0d", i, lat, exp_lat(d_a[i])); else n_pass++;
      n_total++; if (q !== eq) $display("FAIL dir%0d Q got %h exp %h", i, q, eq); else n_pass++;
      n_total++; if (r !== er) $display("FAIL dir%0d R got %h exp %h", i, r, er); else n_pass++;
      n_total++; if ({dz, ov} !== {edz, eov})
        $display("FAIL dir%0d dbz/ovf got %b%b exp %b%b", i, dz, ov, edz, eov); else n_pass++;
      n_total++; if (bb !== 0) $display("FAIL dir%0d busy profile got %0d bad cycles exp 0", i, bb); else n_pass++;
      n_total++; if (nr !== 1) $display("FAIL dir%0d ready pulses got %0d exp 1", i, nr); else n_pass++;
      n_total++; if (hold !== 1'b1) $display("FAIL dir%0d result hold got %b exp 1", i, hold); else n_pass++;
    end
  endtask

  task automatic test_random();
    int lat, bb, nr; logic [N-1:0] D, d, q, r, eq, er; logic m, dz, ov, edz, eov, hold;
    for (int i = 0; i < 24; i++) begin
      m = 1'($urandom); D = pick(); d = pick();
      model(m, D, d, eq, er, edz, eov);
      run_op(m, D, d, lat, q, r, dz, ov, bb, nr, hold);
      n_total++; if (lat !== exp_lat(d) || nr !== 1 || bb !== 0)
        $display("FAIL rnd%0d timing got lat=%0d pulses=%0d busybad=%0d exp lat=%0d pulses=1 busybad=0",
                 i, lat, nr, bb, exp_lat(d)); else n_pass++;
      n_total++; if ({q, r, dz, ov} !== {eq, er, edz, eov})
        $display("FAIL rnd%0d result m=%b %h/%h got Q=%h R=%h dbz=%b ovf=%b exp Q=%h R=%h dbz=%b ovf=%b",
                 i, m, D, d, q, r, dz, ov, eq, er, edz, eov); else n_pass++;
    end
  endtask

  task automatic test_req_while_busy();
    logic [N-1:0] eq, er, q; logic edz, eov; int nr;
    model(1'b0, 16'd1000, 16'd7, eq, er, edz, eov);
    nr = 0; q = '0;
    @(negedge clk); req = 1'b1; signed_mode = 1'b0; Dividend = 16'd1000; Divisor = 16'd7;
    @(posedge clk);
    for (int k = 0; k < N + 8; k++) begin
      @(negedge clk);
      if (ready) begin nr++; q = Q; end
      req = (k == 2 || k == 5 || k == 9 || k == N);
      Dividend = N'($urandom); Divisor = N'($urandom);
    end
    req = 1'b0;
    n_total++; if (nr !== 1) $display("FAIL busy_req ready pulses got %0d exp 1", nr); else n_pass++;
    n_total++; if (q !== eq) $display("FAIL busy_req Q got %h exp %h", q, eq); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL busy_req trailing busy got %b exp 0", busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic m_a [6]; logic [N-1:0] D_a [6], d_a [6];
    logic [N-1:0] eq, er; logic edz, eov; int c, extra;
    for (int i = 0; i < 6; i++) begin
      m_a[i] = 1'($urandom); D_a[i] = pick(); d_a[i] = N'($urandom_range(1, 65535));
    end
    d_a[2] = '0;
    m_a[5] = 1'b0; D_a[5] = 16'd50000; d_a[5] = 16'd7;
    @(negedge clk); req = 1'b1; signed_mode = m_a[0]; Dividend = D_a[0]; Divisor = d_a[0];
    for (int i = 0; i < 6; i++) begin
      model(m_a[i], D_a[i], d_a[i], eq, er, edz, eov);
      c = 0;
      while (c < 40) begin
        @(negedge clk); c++;
        if (ready) break;
        signed_mode = 1'($urandom); Dividend = N'($urandom); Divisor = N'($urandom);
      end
      n_total++; if (c !== exp_lat(d_a[i]) + 1)
        $display("FAIL b2b%0d issue interval got %0d exp %0d", i, c, exp_lat(d_a[i]) + 1); else n_pass++;
      n_total++; if ({Q, R, dbz, ovf} !== {eq, er, edz, eov})
        $display("FAIL b2b%0d result got Q=%h R=%h dbz=%b ovf=%b exp Q=%h R=%h dbz=%b ovf=%b",
                 i, Q, R, dbz, ovf, eq, er, edz, eov); else n_pass++;
      if (i < 5) begin
        signed_mode = m_a[i+1]; Dividend = D_a[i+1]; Divisor = d_a[i+1];
      end else req = 1'b0;
    end
    extra = 0;
    repeat (N + 4) begin @(negedge clk); if (ready || busy) extra++; end
    n_total++; if (extra !== 0) $display("FAIL b2b idle tail got %0d active cycles exp 0", extra); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat, bb, nr, act; logic [N-1:0] q, r; logic dz, ov, hold;
    @(negedge clk); req = 1'b1; signed_mode = 1'b0; Dividend = 16'hFFFF; Divisor = 16'd3;
    @(posedge clk); #1 req = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    n_total++; if (busy !== 1'b1 || Q === '0)
      $display("FAIL mid_pre busy/Q got busy=%b Q=%h exp busy=1 Q!=0", busy, Q); else n_pass++;
    #1 rstn = 1'b0;
    #1;
    n_total++; if ({busy, ready, Q, R, dbz, ovf} !== '0)
      $display("FAIL mid_reset outputs got busy=%b ready=%b Q=%h R=%h dbz=%b ovf=%b exp all 0",
               busy, ready, Q, R, dbz, ovf); else n_pass++;
    act = 0;
    repeat (20) begin @(negedge clk); if (ready || busy) act++; end
    n_total++; if (act !== 0) $display("FAIL mid_reset activity got %0d exp 0", act); else n_pass++;
    rstn = 1'b1;
    run_op(1'b0, 16'd65535, 16'd1, lat, q, r, dz, ov, bb, nr, hold);
    n_total++; if (lat !== N + 1) $display("FAIL post_reset latency got %0d exp %0d", lat, N + 1); else n_pass++;
    n_total++; if ({q, r, dz, ov} !== {16'hFFFF, 16'h0000, 2'b00})
      $display("FAIL post_reset result got Q=%h R=%h dbz=%b ovf=%b exp Q=ffff R=0000 dbz=0 ovf=0",
               q, r, dz, ov); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_req_while_busy();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
